// File: rtl/mem_rr_arbiter_if.sv
// Requester and memory-side signals of the two-port round-robin memory arbiter.
// Signal names carry the arbiter's point of view (_i into the arbiter, _o out of it).
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface mem_rr_arbiter_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  s0_valid_i;
  logic                  s0_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s0_addr_i;
  logic [WIDTH-1:0]      s0_wdata_i;
  logic                  s0_ready_o;
  logic [WIDTH-1:0]      s0_rdata_o;
  logic                  s0_err_o;

  logic                  s1_valid_i;
  logic                  s1_wr_rd_i;
  logic [ADDR_WIDTH-1:0] s1_addr_i;
  logic [WIDTH-1:0]      s1_wdata_i;
  logic                  s1_ready_o;
  logic [WIDTH-1:0]      s1_rdata_o;
  logic                  s1_err_o;

  logic                  m_valid_o;
  logic                  m_wr_rd_o;
  logic [ADDR_WIDTH-1:0] m_addr_o;
  logic [WIDTH-1:0]      m_wdata_o;
  logic                  m_ready_i;
  logic [WIDTH-1:0]      m_rdata_i;

  modport slave (
    input  s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    output s0_ready_o, s0_rdata_o, s0_err_o,
    input  s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    output s1_ready_o, s1_rdata_o, s1_err_o,
    output m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o,
    input  m_ready_i, m_rdata_i
  );

  modport master (
    output s0_valid_i, s0_wr_rd_i, s0_addr_i, s0_wdata_i,
    input  s0_ready_o, s0_rdata_o, s0_err_o,
    output s1_valid_i, s1_wr_rd_i, s1_addr_i, s1_wdata_i,
    input  s1_ready_o, s1_rdata_o, s1_err_o,
    input  m_valid_o, m_wr_rd_o, m_addr_o, m_wdata_o,
    output m_ready_i, m_rdata_i
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// One access at a time: IDLE picks a requester, ACCESS holds the memory request
// until ready or timeout, DONE returns a one-cycle completion to the winner.
module mem_rr_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SIZE       = 2048,
  parameter int unsigned DEPTH      = SIZE / WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_rr_arbiter_if.slave  bus,
  output logic             busy_o
);

  localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
  logic                  s0_ready_q, s0_ready_d;
  logic                  s1_ready_q, s1_ready_d;
  logic [WIDTH-1:0]      s0_rdata_q, s0_rdata_d;
  logic [WIDTH-1:0]      s1_rdata_q, s1_rdata_d;
  logic                  s0_err_q, s0_err_d;
  logic                  s1_err_q, s1_err_d;

  logic                  req_any;
  logic                  pick;
  logic                  timeout_hit;
  logic                  finish;
  logic [WIDTH-1:0]      cap_rdata;

  // Request decode: a tie goes to whichever requester was not served last.
  always_comb begin
    req_any     = bus.s0_valid_i | bus.s1_valid_i;
    pick        = (bus.s0_valid_i & bus.s1_valid_i) ? ~last_q : bus.s1_valid_i;
    timeout_hit = (cnt_q == CNT_LAST);
    finish      = bus.m_ready_i | timeout_hit;
    cap_rdata   = (bus.m_ready_i & ~m_wr_rd_q) ? bus.m_rdata_i : '0;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = ACCESS;
      ACCESS:  if (finish)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; completion fields default to 0 so they pulse in DONE only.
  always_comb begin
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_wr_rd_d  = m_wr_rd_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    s0_ready_d = 1'b0;
    s1_ready_d = 1'b0;
    s0_rdata_d = '0;
    s1_rdata_d = '0;
    s0_err_d   = 1'b0;
    s1_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          gnt_d     = pick;
          cnt_d     = '0;
          m_valid_d = 1'b1;
          if (pick) begin
            m_wr_rd_d = bus.s1_wr_rd_i;
            m_addr_d  = bus.s1_addr_i;
            m_wdata_d = bus.s1_wdata_i;
          end else begin
            m_wr_rd_d = bus.s0_wr_rd_i;
            m_addr_d  = bus.s0_addr_i;
            m_wdata_d = bus.s0_wdata_i;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Memory ready wins over a timeout landing on the same edge.
        if (finish) begin
          m_valid_d = 1'b0;
          if (gnt_q) begin
            s1_ready_d = 1'b1;
            s1_err_d   = ~bus.m_ready_i;
            s1_rdata_d = cap_rdata;
          end else begin
            s0_ready_d = 1'b1;
            s0_err_d   = ~bus.m_ready_i;
            s0_rdata_d = cap_rdata;
          end
        end
      end
      DONE:    last_d = gnt_q;
      default: ;
    endcase
  end

  // Registered outputs and arbitration bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_wr_rd_q  <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      s0_ready_q <= 1'b0;
      s1_ready_q <= 1'b0;
      s0_rdata_q <= '0;
      s1_rdata_q <= '0;
      s0_err_q   <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_wr_rd_q  <= m_wr_rd_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      s0_ready_q <= s0_ready_d;
      s1_ready_q <= s1_ready_d;
      s0_rdata_q <= s0_rdata_d;
      s1_rdata_q <= s1_rdata_d;
      s0_err_q   <= s0_err_d;
      s1_err_q   <= s1_err_d;
    end
  end

  assign bus.m_valid_o  = m_valid_q;
  assign bus.m_wr_rd_o  = m_wr_rd_q;
  assign bus.m_addr_o   = m_addr_q;
  assign bus.m_wdata_o  = m_wdata_q;
  assign bus.s0_ready_o = s0_ready_q;
  assign bus.s0_rdata_o = s0_rdata_q;
  assign bus.s0_err_o   = s0_err_q;
  assign bus.s1_ready_o = s1_ready_q;
  assign bus.s1_rdata_o = s1_rdata_q;
  assign bus.s1_err_o   = s1_err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: behavioural memory with programmable latency,
// table of single-requester accesses, then tie, contention and reset sequences.
module tb_mem_rr_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SIZE  = 2048;
  localparam int unsigned AW    = 8;
  localparam int unsigned TO    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  mem_rr_arbiter #(
    .WIDTH  (WIDTH),
    .SIZE   (SIZE),
    .TIMEOUT(TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus),
    .busy_o(busy)
  );

  typedef struct {
    int         who;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] exp_rdata;
    bit         exp_err;
    int         exp_cyc;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  int          gq[$];
  logic [16:0] mq[$];

  logic [7:0] mem [256];
  int         lat_cfg = 0;
  int         wait_cnt = 0;
  bit         spacing_exact = 1'b0;
  int         last_rdy = -1;
  logic       mv_prev = 1'b0;

  function automatic logic [7:0] pre(input logic [7:0] a);
    return a ^ 8'h96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (id == 0) begin
      bus.s0_valid_i = v; bus.s0_wr_rd_i = wr; bus.s0_addr_i = a; bus.s0_wdata_i = d;
    end else begin
      bus.s1_valid_i = v; bus.s1_wr_rd_i = wr; bus.s1_addr_i = a; bus.s1_wdata_i = d;
    end
  endtask

  // Issue one request, hold it until this requester's ready_o, then release.
  task automatic do_req(input int id, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] er,
                        input logic ee, output int cyc);
    exp_t e;
    logic got;
    e.rdata = er;
    e.err   = ee;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
    drive(id, 1'b1, wr, a, d);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      got = (id == 0) ? bus.s0_ready_o : bus.s1_ready_o;
    end
    chk($sformatf("ready_wait_s%0d", id), 32'(got), 32'(1));
    drive(id, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_m"}, 32'({bus.m_valid_o, bus.m_wr_rd_o, bus.m_addr_o, bus.m_wdata_o}), 32'(0));
    chk({name, "_s"}, 32'({bus.s0_ready_o, bus.s0_err_o, bus.s0_rdata_o,
                           bus.s1_ready_o, bus.s1_err_o, bus.s1_rdata_o}), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic take_ready(input int id);
    exp_t e;
    int   g;
    chk($sformatf("ready_expected_s%0d", id), 32'((id == 0) ? q0.size() : q1.size()) != 0, 32'(1));
    if (id == 0 && q0.size() != 0) begin
      e = q0.pop_front();
      chk("s0_rdata", 32'(bus.s0_rdata_o), 32'(e.rdata));
      chk("s0_err", 32'(bus.s0_err_o), 32'(e.err));
    end
    if (id == 1 && q1.size() != 0) begin
      e = q1.pop_front();
      chk("s1_rdata", 32'(bus.s1_rdata_o), 32'(e.rdata));
      chk("s1_err", 32'(bus.s1_err_o), 32'(e.err));
    end
    chk("grant_expected", 32'(gq.size() != 0), 32'(1));
    if (gq.size() != 0) begin
      g = gq.pop_front();
      chk("grant_order", 32'(id), 32'(g));
    end
  endtask

  // Cycle counter used for completion spacing.
  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Memory model: answers after lat_cfg extra cycles, noise on rdata otherwise.
  initial begin
    bus.m_ready_i = 1'b0;
    bus.m_rdata_i = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.m_valid_o && !bus.m_ready_i) begin
        if (wait_cnt >= lat_cfg) begin
          bus.m_ready_i = 1'b1;
          if (bus.m_wr_rd_o) begin
            mem[bus.m_addr_o] = bus.m_wdata_o;
            bus.m_rdata_i = 8'($urandom);
          end else begin
            bus.m_rdata_i = mem[bus.m_addr_o];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          bus.m_rdata_i = 8'($urandom);
        end
      end else begin
        bus.m_ready_i = 1'b0;
        bus.m_rdata_i = 8'($urandom);
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: completions and memory-request launches.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      last_rdy = -1;
    end else begin
      if (bus.s0_ready_o || bus.s1_ready_o) begin
        chk("one_ready", 32'(bus.s0_ready_o & bus.s1_ready_o), 32'(0));
        if (bus.s0_ready_o) take_ready(0);
        if (bus.s1_ready_o) take_ready(1);
        if (last_rdy >= 0) begin
          if (spacing_exact) chk("spacing", 32'(cycle - last_rdy), 32'(3));
          else               chk("spacing_min", 32'((cycle - last_rdy) >= 3), 32'(1));
        end
        last_rdy = cycle;
      end
      if (bus.m_valid_o && !mv_prev) begin
        chk("m_req_expected", 32'(mq.size() != 0), 32'(1));
        if (mq.size() != 0)
          chk("m_req", 32'({bus.m_wr_rd_o, bus.m_addr_o, bus.m_wdata_o}), 32'(mq.pop_front()));
      end
    end
    mv_prev = bus.m_valid_o;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog: actual=expired required=finish");
    $fatal(1, "time limit");
  end

  vec_t vt[12];
  int   c, c0, c1;

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int unsigned a = 0; a < 256; a++) mem[a] = pre(8'(a));
    mem[8'h40] = 8'h77;
    mem[8'h30] = 8'h3C;

    //          who wr addr   wdata  lat  rdata  err cyc
    vt[0]  = '{0, 1, 8'h15, 8'hA5, 0,   8'h00, 0, 2};
    vt[1]  = '{0, 0, 8'h15, 8'hEE, 0,   8'hA5, 0, 2};
    vt[2]  = '{1, 1, 8'h20, 8'h5A, 2,   8'h00, 0, 4};
    vt[3]  = '{1, 0, 8'h20, 8'h00, 1,   8'h5A, 0, 3};
    vt[4]  = '{0, 0, 8'h20, 8'h11, 3,   8'h5A, 0, 5};
    vt[5]  = '{1, 1, 8'hFF, 8'hC3, 0,   8'h00, 0, 2};
    vt[6]  = '{0, 0, 8'hFF, 8'h00, 0,   8'hC3, 0, 2};
    vt[7]  = '{1, 0, 8'h40, 8'h00, 200, 8'h00, 1, 65};
    vt[8]  = '{0, 0, 8'h30, 8'h00, 63,  8'h3C, 0, 65};
    vt[9]  = '{1, 0, 8'h30, 8'h00, 64,  8'h00, 1, 65};
    vt[10] = '{0, 1, 8'h00, 8'h81, 5,   8'h00, 0, 7};
    vt[11] = '{1, 0, 8'h00, 8'h00, 0,   8'h81, 0, 2};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-requester table.
    spacing_exact = 1'b0;
    for (int i = 0; i < 12; i++) begin
      lat_cfg = vt[i].lat;
      gq.push_back(vt[i].who);
      mq.push_back({vt[i].wr, vt[i].addr, vt[i].wdata});
      do_req(vt[i].who, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err, c);
      chk($sformatf("latency[%0d]", i), 32'(c), 32'(vt[i].exp_cyc));
      @(negedge clk);
      chk($sformatf("idle_after[%0d]", i), 32'({busy, bus.s0_ready_o, bus.s1_ready_o, bus.m_valid_o}), 32'(0));
    end

    // Simultaneous writes straight after reset: s0 first, then s1.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 0;
    spacing_exact = 1'b1;
    gq.push_back(0); gq.push_back(1);
    mq.push_back({1'b1, 8'h01, 8'h11});
    mq.push_back({1'b1, 8'h02, 8'h22});
    fork
      do_req(0, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0, c0);
      do_req(1, 1'b1, 8'h02, 8'h22, 8'h00, 1'b0, c1);
    join
    chk("tie_lat_s0", 32'(c0), 32'(2));
    chk("tie_lat_s1", 32'(c1), 32'(5));
    @(negedge clk);
    spacing_exact = 1'b0;
    gq.push_back(1); mq.push_back({1'b0, 8'h01, 8'h00});
    do_req(1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0, c);
    @(negedge clk);
    gq.push_back(0); mq.push_back({1'b0, 8'h02, 8'h00});
    do_req(0, 1'b0, 8'h02, 8'h00, 8'h22, 1'b0, c);
    @(negedge clk);

    // Continuous contention: 8 reads each, strict alternation every 3 cycles.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spacing_exact = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gq.push_back(0); gq.push_back(1);
      mq.push_back({1'b0, 8'(8'h80 + i), 8'h00});
      mq.push_back({1'b0, 8'(8'hC0 + i), 8'h00});
    end
    fork
      begin
        int cc;
        for (int i = 0; i < 8; i++)
          do_req(0, 1'b0, 8'(8'h80 + i), 8'h00, pre(8'(8'h80 + i)), 1'b0, cc);
      end
      begin
        int cc;
        for (int i = 0; i < 8; i++)
          do_req(1, 1'b0, 8'(8'hC0 + i), 8'h00, pre(8'(8'hC0 + i)), 1'b0, cc);
      end
    join
    repeat (2) @(negedge clk);
    chk("contention_drained", 32'(q0.size() + q1.size() + gq.size()), 32'(0));

    // Reset during ACCESS abandons the access; first tie afterwards goes to s0.
    lat_cfg = 200;
    mq.push_back({1'b0, 8'h10, 8'h33});
    drive(0, 1'b1, 1'b0, 8'h10, 8'h33);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'({busy, bus.m_valid_o}), 32'(3));
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 0;
    gq.push_back(0); gq.push_back(1);
    mq.push_back({1'b0, 8'h81, 8'h00});
    mq.push_back({1'b0, 8'hC1, 8'h00});
    fork
      do_req(0, 1'b0, 8'h81, 8'h00, pre(8'h81), 1'b0, c0);
      do_req(1, 1'b0, 8'hC1, 8'h00, pre(8'hC1), 1'b0, c1);
    join
    chk("post_reset_tie_s0_first", 32'(c0 < c1), 32'(1));

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(q0.size() + q1.size() + gq.size() + mq.size()), 32'(0));
    chk("final_idle", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
